// File: rtl/instruction_fetch.sv
// Instruction fetch unit: requests one word at a time from instruction memory
// and buffers fetched {addr, data} pairs in a 2-entry FIFO for the decoder.
module instruction_fetch #(
    parameter int databus_width = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [databus_width-1:0] pc_value,
    output logic                     pc_increase,
    output logic                     pc_load,
    output logic [databus_width-1:0] pc_load_data,
    input  logic                     redirect,
    input  logic [databus_width-1:0] redirect_addr,
    output logic                     mem_req,
    output logic [databus_width-1:0] mem_addr,
    input  logic                     mem_ack,
    input  logic [databus_width-1:0] mem_rdata,
    output logic                     instr_valid,
    output logic [databus_width-1:0] instr_data,
    output logic [databus_width-1:0] instr_addr,
    input  logic                     instr_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t state, state_next;

    logic [databus_width-1:0] fifo_data [2];
    logic [databus_width-1:0] fifo_addr [2];
    logic [1:0]               count;
    logic                     wr_ptr;
    logic                     rd_ptr;
    logic                     push;
    logic                     pop;
    logic                     start;

    assign instr_valid = (count != 2'd0);
    assign instr_data  = fifo_data[rd_ptr];
    assign instr_addr  = fifo_addr[rd_ptr];
    assign pop         = instr_valid && instr_ready;

    always_comb begin
        state_next   = state;
        push         = 1'b0;
        start        = 1'b0;
        pc_increase  = 1'b0;
        pc_load      = 1'b0;
        pc_load_data = '0;
        mem_req      = 1'b0;

        if (redirect) begin
            pc_load      = 1'b1;
            pc_load_data = redirect_addr;
        end

        case (state)
            IDLE: begin
                if (redirect) begin
                    state_next = GAP;
                end else if (enable && count <= 2'd1) begin
                    state_next = REQ;
                    start      = 1'b1;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_next = GAP;
                    if (!redirect) begin
                        push        = 1'b1;
                        pc_increase = 1'b1;
                    end
                end else if (redirect) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                state_next = redirect ? GAP : IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Reset outranks a same-cycle redirect or ack on the pulse outputs.
        if (reset) begin
            pc_load      = 1'b0;
            pc_load_data = '0;
            pc_increase  = 1'b0;
            push         = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            mem_addr <= '0;
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_addr[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (start) begin
                mem_addr <= pc_value;
            end
            if (push) begin
                fifo_data[wr_ptr] <= mem_rdata;
                fifo_addr[wr_ptr] <= mem_addr;
            end
            // A flush wins over a same-cycle pop; push never coincides with it.
            if (redirect) begin
                count  <= 2'd0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                wr_ptr <= wr_ptr ^ push;
                rd_ptr <= rd_ptr ^ pop;
                count  <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a cycle-vector table for the
// directed corner cases, then a scoreboarded stream with a PC and memory model.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] pc_value;
    logic        pc_increase;
    logic        pc_load;
    logic [15:0] pc_load_data;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic [15:0] instr_addr;
    logic        instr_ready;

    instruction_fetch #(.databus_width(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .pc_value     (pc_value),
        .pc_increase  (pc_increase),
        .pc_load      (pc_load),
        .pc_load_data (pc_load_data),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .instr_valid  (instr_valid),
        .instr_data   (instr_data),
        .instr_addr   (instr_addr),
        .instr_ready  (instr_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst, en;
        logic [15:0] pc;
        logic        rd;
        logic [15:0] ra;
        logic        ack;
        logic [15:0] rdata;
        logic        rdy;
        logic        mreq;
        logic [15:0] maddr;
        logic        inc, load, ivalid, chkd;
        logic [15:0] idata, iaddr;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];
    int          compared = 0;
    int          failed   = 0;
    logic [15:0] pc_model;
    logic        draining;
    int          wait_cnt;
    int          lat;
    int          pushes;
    int          pops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, en, input logic [15:0] pc, input logic rd,
                       input logic [15:0] ra, input logic ack, input logic [15:0] rdata,
                       input logic rdy, input logic mreq, input logic [15:0] maddr,
                       input logic inc, load, ivalid, chkd,
                       input logic [15:0] idata, iaddr);
        vec_t v;
        v.rst = rst; v.en = en; v.pc = pc; v.rd = rd; v.ra = ra; v.ack = ack;
        v.rdata = rdata; v.rdy = rdy; v.mreq = mreq; v.maddr = maddr; v.inc = inc;
        v.load = load; v.ivalid = ivalid; v.chkd = chkd; v.idata = idata; v.iaddr = iaddr;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; enable = 1'b0; redirect = 1'b0; mem_ack = 1'b0;
        instr_ready = 1'b0; pc_value = '0; redirect_addr = '0; mem_rdata = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        pc_model = '0; draining = 1'b0; wait_cnt = 0; lat = 0;
        sb.delete();
    endtask

    // One scoreboarded cycle: memory model answers after 'lat' REQ cycles,
    // expected words are queued on ack and compared when the decoder pops.
    task automatic step(input logic en, input logic rdy, input logic rd, input logic [15:0] ra);
        logic        ack_now;
        logic        exp_inc;
        logic [31:0] e;
        @(negedge clock);
        enable = en; instr_ready = rdy; redirect = rd; redirect_addr = ra;
        pc_value = pc_model;
        ack_now = mem_req && (wait_cnt >= lat);
        mem_ack = ack_now;
        mem_rdata = 16'($urandom);
        #1;
        exp_inc = mem_req && ack_now && !rd && !draining;
        chk("sb_pc_increase", {31'd0, pc_increase}, {31'd0, exp_inc});
        chk("sb_pc_load", {31'd0, pc_load}, {31'd0, rd});
        if (rd) chk("sb_pc_load_data", {16'd0, pc_load_data}, {16'd0, ra});
        chk("sb_instr_valid", {31'd0, instr_valid}, {31'd0, sb.size() != 0});
        if (instr_valid && rdy) begin
            if (sb.size() == 0) begin
                chk("sb_pop_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_head", {instr_addr, instr_data}, e);
                pops++;
            end
        end
        if (exp_inc) begin
            chk("sb_mem_addr", {16'd0, mem_addr}, {16'd0, pc_model});
            sb.push_back({pc_model, mem_rdata});
            pushes++;
        end
        if (rd) sb.delete();
        chk("sb_depth", {31'd0, sb.size() <= 2}, 32'd1);
        if (mem_req && ack_now) draining = 1'b0;
        else if (mem_req && rd) draining = 1'b1;
        if (ack_now) begin
            wait_cnt = 0;
            lat = $urandom_range(0, 2);
        end else if (mem_req) begin
            wait_cnt++;
        end
        if (rd) pc_model = ra;
        else if (exp_inc) pc_model = pc_model + 16'd1;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; redirect = 1'b0; mem_ack = 1'b0;
        instr_ready = 1'b0; pc_value = '0; redirect_addr = '0; mem_rdata = '0;

        //  rst en pc     rd ra      ack rdata    rdy | mreq maddr  inc ld iv cd idata    iaddr
        add(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 0, 1, 16'h0000, 16'h0000);
        add(0, 1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0,  1, 16'h0010, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0010, 0, 16'h0000, 1, 16'hABCD, 0,  1, 16'h0010, 1, 0, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0011, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0010, 0, 0, 1, 1, 16'hABCD, 16'h0010);
        add(0, 1, 16'h0011, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0010, 0, 0, 1, 1, 16'hABCD, 16'h0010);
        add(0, 1, 16'h0011, 0, 16'h0000, 0, 16'h0000, 1,  1, 16'h0011, 0, 0, 1, 1, 16'hABCD, 16'h0010);
        add(0, 1, 16'h0011, 0, 16'h0000, 0, 16'h0000, 0,  1, 16'h0011, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0011, 1, 16'h0200, 0, 16'h0000, 0,  1, 16'h0011, 0, 1, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0200, 0, 16'h0000, 0, 16'h0000, 0,  1, 16'h0011, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0200, 0, 16'h0000, 1, 16'h1111, 0,  1, 16'h0011, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0200, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0011, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0200, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0011, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0200, 1, 16'h0300, 1, 16'h2222, 0,  1, 16'h0200, 0, 1, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0300, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0200, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0300, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0200, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0300, 0, 16'h0000, 1, 16'h3333, 0,  1, 16'h0300, 1, 0, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0301, 1, 16'h0040, 0, 16'h0000, 0,  0, 16'h0300, 0, 1, 1, 1, 16'h3333, 16'h0300);
        add(0, 1, 16'h0040, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0300, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0040, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0300, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0040, 0, 16'h0000, 0, 16'h0000, 0,  1, 16'h0040, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add(1, 1, 16'h0040, 0, 16'h0000, 0, 16'h0000, 0,  1, 16'h0040, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0040, 0, 16'h0000, 1, 16'h5555, 0,  0, 16'h0000, 0, 0, 0, 1, 16'h0000, 16'h0000);
        add(0, 0, 16'h0040, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0041, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0041, 0, 16'h0000, 1, 16'h6666, 0,  1, 16'h0041, 1, 0, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0042, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0041, 0, 0, 1, 1, 16'h6666, 16'h0041);
        add(0, 1, 16'h0042, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0041, 0, 0, 1, 1, 16'h6666, 16'h0041);
        add(0, 1, 16'h0042, 0, 16'h0000, 1, 16'h7777, 1,  1, 16'h0042, 1, 0, 1, 1, 16'h6666, 16'h0041);
        add(0, 0, 16'h0043, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0042, 0, 0, 1, 1, 16'h7777, 16'h0042);
        add(0, 0, 16'h0043, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0042, 0, 0, 1, 1, 16'h7777, 16'h0042);
        add(0, 0, 16'h0043, 1, 16'h0500, 0, 16'h0000, 1,  0, 16'h0042, 0, 1, 1, 1, 16'h7777, 16'h0042);
        add(0, 0, 16'h0500, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0042, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0500, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0042, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0500, 0, 16'h0000, 0, 16'h0000, 0,  1, 16'h0500, 0, 0, 0, 0, 16'h0000, 16'h0000);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            reset = vecs[i].rst; enable = vecs[i].en; pc_value = vecs[i].pc;
            redirect = vecs[i].rd; redirect_addr = vecs[i].ra; mem_ack = vecs[i].ack;
            mem_rdata = vecs[i].rdata; instr_ready = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d_mem_req", i), {31'd0, mem_req}, {31'd0, vecs[i].mreq});
            chk($sformatf("v%0d_mem_addr", i), {16'd0, mem_addr}, {16'd0, vecs[i].maddr});
            chk($sformatf("v%0d_pc_increase", i), {31'd0, pc_increase}, {31'd0, vecs[i].inc});
            chk($sformatf("v%0d_pc_load", i), {31'd0, pc_load}, {31'd0, vecs[i].load});
            if (vecs[i].load)
                chk($sformatf("v%0d_pc_load_data", i), {16'd0, pc_load_data}, {16'd0, vecs[i].ra});
            chk($sformatf("v%0d_instr_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].ivalid});
            if (vecs[i].chkd)
                chk($sformatf("v%0d_instr_head", i), {instr_addr, instr_data},
                    {vecs[i].iaddr, vecs[i].idata});
        end

        // Backpressure: immediate acks, decoder stalled -> exactly two words buffered.
        do_reset();
        pushes = 0; pops = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 16'h0000);
        chk("bp_pushes", pushes, 32'd2);
        chk("bp_mem_req_idle", {31'd0, mem_req}, 32'd0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 16'h0000);
        chk("bp_resume", {31'd0, pushes > 2}, 32'd1);
        chk("bp_popped", {31'd0, pops >= 2}, 32'd1);

        // Random stream: variable ack latency, stalls, disables and redirects.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 22) == 0, 16'($urandom));
        end
        chk("stream_progress", {31'd0, pops > 20}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
